// File: rtl/handshake_responder.sv
// -----------------------------------------------------------------------------
// handshake_responder
//
// Request/response endpoint for a valid/ready stream. Each accepted request
// beat is queued in a DEPTH-entry FIFO as (req_data + 1), and one response beat
// per request is returned, strictly in order, on an independent rsp channel.
// There is no combinational path from the req channel to the rsp channel.
// Every response is therefore registered, with at least one cycle of latency.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset (clears pointers and storage)
//   en         accept enable; low blocks new requests, responses still drain
//   req_valid  request beat valid
//   req_data   request payload [WIDTH-1:0]
//   req_ready  request can be accepted this cycle (en & ~full, state only)
//   rsp_valid  response beat valid (FIFO not empty)
//   rsp_data   response payload [WIDTH-1:0], head entry of the FIFO
//   rsp_ready  downstream accepts the response this cycle
//   level      number of queued responses [ADDR_W:0], 0..DEPTH
//   rsp_seq    (RSP_SEQ_EN only) 8-bit accept sequence number of the head entry
//
// Build option:
//   RSP_SEQ_EN  when defined, each entry also stores an 8-bit accept counter
//               value. That value is presented on rsp_seq alongside rsp_data.
//
// Parameters:
//   WIDTH   data width of request/response beats
//   DEPTH   FIFO entries, power of two, >= 2
//   ADDR_W  log2(DEPTH)
// -----------------------------------------------------------------------------
module handshake_responder #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req_valid,
  input  logic [WIDTH-1:0]  req_data,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  input  logic              rsp_ready,
  output logic [ADDR_W:0]   level
`ifdef RSP_SEQ_EN
  ,
  output logic [7:0]        rsp_seq
`endif
);

  localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so that full and empty can be told apart
  // without a separate occupancy counter.
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   wr_ptr_nxt;
  logic [ADDR_W:0]   rd_ptr_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  // ---------------------------------------------------------------------------
  // Status, derived from registered pointers only
  // ---------------------------------------------------------------------------
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // req_ready never looks at req_valid or rsp_ready. A pop on the same edge
  // cannot make room for a push in that cycle. The freed slot becomes visible
  // on the following cycle.
  assign req_ready = en & ~full;
  assign rsp_valid = ~empty;

  assign push = req_valid & req_ready;
  assign pop  = rsp_valid & rsp_ready;

  // The pointer difference wraps modulo 2^(ADDR_W+1). That is exactly the
  // occupancy, because DEPTH = 2^ADDR_W.
  assign level = wr_ptr - rd_ptr;

  // The head entry is read directly from registered storage. The output is
  // therefore stable for as long as rd_ptr does not move.
  assign rsp_data = mem[rd_ptr[ADDR_W-1:0]];

  // ---------------------------------------------------------------------------
  // Pointer next-state
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves a
  // variable unassigned would infer a latch.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (push) begin
      wr_ptr_nxt = wr_ptr + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr + PTR_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is reset on purpose. rsp_data must read 0 out of
  // reset, and a reset discards queued beats. This rules out mapping the array
  // onto a RAM macro, which is acceptable at this depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      // The increment wraps naturally at the data width (all-ones -> 0).
      mem[wr_ptr[ADDR_W-1:0]] <= req_data + DATA_ONE;
    end
  end

`ifdef RSP_SEQ_EN
  // ---------------------------------------------------------------------------
  // Accept sequence tags
  // ---------------------------------------------------------------------------
  // Each accepted beat is tagged with the running accept count. This lets a
  // downstream checker spot drops or duplicates independently of the payload.
  logic [7:0] acc_cnt;
  logic [7:0] seq_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        seq_mem[i] <= '0;
      end
    end else if (push) begin
      seq_mem[wr_ptr[ADDR_W-1:0]] <= acc_cnt;
      acc_cnt                     <= acc_cnt + 8'd1;
    end
  end

  assign rsp_seq = seq_mem[rd_ptr[ADDR_W-1:0]];
`endif

endmodule

// File: tb/tb_handshake_responder.sv
// -----------------------------------------------------------------------------
// tb_handshake_responder
//
// Directed bench for handshake_responder. Stimulus is driven 1 time unit after
// each rising edge, and outputs are sampled at that same point. A small queue
// model tracks the expected FIFO contents, and hand-computed values cover the
// named scenarios. Define RSP_SEQ_EN for both bench and RTL to also exercise
// rsp_seq.
// -----------------------------------------------------------------------------
module tb_handshake_responder;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              en        = 1'b0;
  logic              req_valid = 1'b0;
  logic [WIDTH-1:0]  req_data  = '0;
  logic              rsp_ready = 1'b0;
  logic              req_ready;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_data;
  logic [ADDR_W:0]   level;
`ifdef RSP_SEQ_EN
  logic [7:0]        rsp_seq;
`endif

  handshake_responder #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .level     (level)
`ifdef RSP_SEQ_EN
    ,
    .rsp_seq   (rsp_seq)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected FIFO contents (payload and accept tag) plus the expected accept
  // counter.
  logic [7:0] mq [$];
  logic [7:0] sq [$];
  logic [7:0] seq_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, rsp_valid, (mq.size() != 0));
    check({tag, ".level"}, level, mq.size());
    check({tag, ".ready"}, req_ready, (en && mq.size() < DEPTH));
    if (mq.size() != 0) begin
      check({tag, ".data"}, rsp_data, mq[0]);
`ifdef RSP_SEQ_EN
      check({tag, ".seq"}, rsp_seq, sq[0]);
`endif
    end
  endtask

  // Apply the current inputs across one rising edge, advance the model and
  // compare every output.
  task automatic cycle(input string tag);
    bit         push;
    bit         pop;
    logic [7:0] nv;
    push = req_valid && en && (mq.size() < DEPTH);
    pop  = rsp_ready && (mq.size() != 0);
    nv   = req_data + 8'd1;
    tick();
    if (pop) begin
      mq.delete(0);
      sq.delete(0);
    end
    if (push) begin
      mq.push_back(nv);
      sq.push_back(seq_cnt);
      seq_cnt = seq_cnt + 8'd1;
    end
    compare_model(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         sent;
    int         got;
    bit         push_ok;
    logic [7:0] e;

    // ---------------- Reset state ----------------
    rst_n = 1'b0;
    en    = 1'b1;
    #2;
    check("rst.valid", rsp_valid, 1'b0);
    check("rst.data",  rsp_data, 8'h00);
    check("rst.level", level, 3'd0);
    check("rst.ready_en1", req_ready, 1'b1);
    en = 1'b0;
    #1;
    check("rst.ready_en0", req_ready, 1'b0);
    en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    mq.delete();
    sq.delete();
    seq_cnt = '0;

    // ---------------- Single beat ----------------
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_data  = 8'h05;
    check("t1.pre_valid", rsp_valid, 1'b0);
    cycle("t1.push");
    req_valid = 1'b0;
    check("t1.valid", rsp_valid, 1'b1);
    check("t1.data",  rsp_data, 8'h06);
    check("t1.level", level, 3'd1);
`ifdef RSP_SEQ_EN
    check("t1.seq", rsp_seq, 8'd0);
`endif
    cycle("t1.pop");
    check("t1.level0", level, 3'd0);
    check("t1.empty",  rsp_valid, 1'b0);

    // ---------------- Fill to full ----------------
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_data  = 8'h10 + i[7:0];
      cycle("t2.fill");
    end
    check("t2.full_level", level, 3'd4);
    check("t2.full_ready", req_ready, 1'b0);
    check("t2.head", rsp_data, 8'h11);
    req_data = 8'h20;
    cycle("t2.held");
    check("t2.held_level", level, 3'd4);
    rsp_ready = 1'b1;
    cycle("t2.pop1");
    check("t2.pop1_level", level, 3'd3);
    check("t2.pop1_ready", req_ready, 1'b1);
    check("t2.pop1_data",  rsp_data, 8'h12);
    cycle("t2.accept");
    req_valid = 1'b0;
    check("t2.accept_level", level, 3'd3);
    check("t2.accept_data",  rsp_data, 8'h13);
    cycle("t2.drain");
    check("t2.d14", rsp_data, 8'h14);
    cycle("t2.drain");
    check("t2.d21", rsp_data, 8'h21);
    cycle("t2.drain");
    check("t2.d_empty", level, 3'd0);

    // ---------------- Wrap and data overflow ----------------
    sent = 0;
    got  = 0;
    for (int c = 0; c < 200 && got < 12; c++) begin
      rsp_ready = c[0];
      req_valid = (sent < 12);
      req_data  = 8'hFC + sent[7:0];
      push_ok   = req_valid && en && (mq.size() < DEPTH);
      if (rsp_valid && rsp_ready) begin
        e = 8'hFD + got[7:0];
        check("t3.order", rsp_data, e);
        got++;
      end
      cycle("t3");
      if (push_ok) sent++;
    end
    req_valid = 1'b0;
    check("t3.count", got, 12);
    check("t3.empty", level, 3'd0);

    // ---------------- Stability under backpressure ----------------
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_data  = 8'h40;
    cycle("t4.push");
    req_data  = 8'h41;
    cycle("t4.push");
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("t4.hold");
      check("t4.hold_valid", rsp_valid, 1'b1);
      check("t4.hold_data",  rsp_data, 8'h41);
    end

    // ---------------- en gating ----------------
    en        = 1'b0;
    req_valid = 1'b1;
    req_data  = 8'h77;
    #1;
    check("t5.ready", req_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("t5.blocked");
      check("t5.level", level, 3'd2);
    end
    rsp_ready = 1'b1;
    cycle("t5.drain");
    check("t5.d42", rsp_data, 8'h42);
    cycle("t5.drain");
    check("t5.level0", level, 3'd0);
    check("t5.empty",  rsp_valid, 1'b0);
    en        = 1'b1;
    req_valid = 1'b0;

    // ---------------- Reset mid-stream ----------------
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_data = 8'h50 + i[7:0];
      cycle("t6.fill");
    end
    req_valid = 1'b0;
    check("t6.level3", level, 3'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6.rst_valid", rsp_valid, 1'b0);
    check("t6.rst_level", level, 3'd0);
    check("t6.rst_data",  rsp_data, 8'h00);
    mq.delete();
    sq.delete();
    seq_cnt   = '0;
    req_valid = 1'b1;
    req_data  = 8'h99;
    tick();
    check("t6.rst_noaccept", level, 3'd0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("t6.post_level", level, 3'd0);
    req_valid = 1'b1;
    req_data  = 8'h60;
    cycle("t6.push");
    req_valid = 1'b0;
    check("t6.first_data", rsp_data, 8'h61);
`ifdef RSP_SEQ_EN
    check("t6.first_seq", rsp_seq, 8'd0);
`endif
    rsp_ready = 1'b1;
    cycle("t6.pop");
    check("t6.final_level", level, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
